// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan scheduler: slot sequencing, blanking, brightness PWM, guard band,
// and double-buffered display data that only changes on a frame boundary.
module display_scan_controller #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DIV_W       = 17,
    parameter int unsigned GUARD       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_mask_in,
    input  logic [3:0]  brightness_in,
    output logic        load_ack,
    output logic [1:0]  LED_activating_counter,
    output logic [3:0]  digit_value,
    output logic        digit_blank,
    output logic        frame_start
);

    typedef enum logic [0:0] {StIdle, StPending} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         slot_q, slot_d;
    logic [3:0]         pwm_q, pwm_d;
    logic [15:0]        act_digits_q, act_digits_d, pend_digits_q, pend_digits_d;
    logic [3:0]         act_mask_q, act_mask_d, pend_mask_q, pend_mask_d;
    logic [3:0]         act_bright_q, act_bright_d, pend_bright_q, pend_bright_d;
    logic               load_ack_q, load_ack_d;
    logic               frame_start_q, frame_start_d;
    logic [3:0]         value_q, value_d;
    logic               blank_q, blank_d;
    logic               last_div, wrap;
    logic [1:0]         sel;

    always_comb begin
        last_div      = (div_q == DIV_W'(REFRESH_DIV - 1));
        wrap          = last_div && (slot_q == 2'd3);
        div_d         = last_div ? '0 : div_q + DIV_W'(1);
        slot_d        = last_div ? slot_q + 2'd1 : slot_q;
        pwm_d         = pwm_q + 4'd1;
        frame_start_d = wrap;

        state_d       = state_q;
        pend_digits_d = pend_digits_q;
        pend_mask_d   = pend_mask_q;
        pend_bright_d = pend_bright_q;
        act_digits_d  = act_digits_q;
        act_mask_d    = act_mask_q;
        act_bright_d  = act_bright_q;
        load_ack_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A load landing on the wrap edge is only staged; it commits next frame.
                if (load) begin
                    pend_digits_d = digits_in;
                    pend_mask_d   = blank_mask_in;
                    pend_bright_d = brightness_in;
                    state_d       = StPending;
                end
            end
            StPending: begin
                if (wrap) begin
                    act_digits_d = pend_digits_q;
                    act_mask_d   = pend_mask_q;
                    act_bright_d = pend_bright_q;
                    load_ack_d   = 1'b1;
                end
                if (load) begin
                    pend_digits_d = digits_in;
                    pend_mask_d   = blank_mask_in;
                    pend_bright_d = brightness_in;
                end else if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from next-state so slot, value and blank all update on one edge.
        sel     = ~slot_d;
        value_d = act_digits_d[{sel, 2'b00} +: 4];
        blank_d = act_mask_d[sel] || (div_d < DIV_W'(GUARD)) || (pwm_d > act_bright_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            div_q         <= '0;
            slot_q        <= 2'd0;
            pwm_q         <= 4'd0;
            act_digits_q  <= 16'h0000;
            act_mask_q    <= 4'hF;
            act_bright_q  <= 4'hF;
            pend_digits_q <= 16'h0000;
            pend_mask_q   <= 4'h0;
            pend_bright_q <= 4'h0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            value_q       <= 4'd0;
            blank_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            slot_q        <= slot_d;
            pwm_q         <= pwm_d;
            act_digits_q  <= act_digits_d;
            act_mask_q    <= act_mask_d;
            act_bright_q  <= act_bright_d;
            pend_digits_q <= pend_digits_d;
            pend_mask_q   <= pend_mask_d;
            pend_bright_q <= pend_bright_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
        end
    end

    assign load_ack               = load_ack_q;
    assign LED_activating_counter = slot_q;
    assign digit_value            = value_q;
    assign digit_blank            = blank_q;
    assign frame_start            = frame_start_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: two instances (short and long slots) checked every cycle
// against a time-based model, plus directed scenarios with hand-computed expectations.
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  blank_mask_in = 4'h0;
    logic [3:0]  brightness_in = 4'h0;

    logic        ack_a, blank_a, fs_a, ack_b, blank_b, fs_b;
    logic [1:0]  led_a, led_b;
    logic [3:0]  val_a, val_b;
    logic [8:0]  obs_a, obs_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    display_scan_controller #(.REFRESH_DIV(4), .DIV_W(2), .GUARD(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .load(load), .digits_in(digits_in),
        .blank_mask_in(blank_mask_in), .brightness_in(brightness_in), .load_ack(ack_a),
        .LED_activating_counter(led_a), .digit_value(val_a), .digit_blank(blank_a),
        .frame_start(fs_a)
    );

    display_scan_controller #(.REFRESH_DIV(32), .DIV_W(5), .GUARD(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .load(load), .digits_in(digits_in),
        .blank_mask_in(blank_mask_in), .brightness_in(brightness_in), .load_ack(ack_b),
        .LED_activating_counter(led_b), .digit_value(val_b), .digit_blank(blank_b),
        .frame_start(fs_b)
    );

    assign obs_a = {ack_a, led_a, val_a, blank_a, fs_a};
    assign obs_b = {ack_b, led_b, val_b, blank_b, fs_b};

    function automatic int unsigned rd(input int i);
        return (i == 0) ? 32'd4 : 32'd32;
    endfunction

    function automatic int unsigned gd(input int i);
        return (i == 0) ? 32'd1 : 32'd2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: everything is derived from cycles elapsed since reset release.
    int unsigned m_t[2];
    logic        m_has[2], m_ack[2];
    logic [15:0] m_pd[2], m_ad[2];
    logic [3:0]  m_pm[2], m_pb[2], m_am[2], m_ab[2];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_t[i] <= 0; m_has[i] <= 1'b0; m_ack[i] <= 1'b0;
                m_pd[i] <= 16'h0; m_pm[i] <= 4'h0; m_pb[i] <= 4'h0;
                m_ad[i] <= 16'h0; m_am[i] <= 4'hF; m_ab[i] <= 4'hF;
            end else begin
                m_t[i]   <= m_t[i] + 1;
                m_ack[i] <= 1'b0;
                if (m_has[i] && ((m_t[i] + 1) % (4 * rd(i))) == 0) begin
                    m_ad[i] <= m_pd[i]; m_am[i] <= m_pm[i]; m_ab[i] <= m_pb[i];
                    m_ack[i] <= 1'b1; m_has[i] <= 1'b0;
                end
                if (load) begin
                    m_pd[i] <= digits_in; m_pm[i] <= blank_mask_in; m_pb[i] <= brightness_in;
                    m_has[i] <= 1'b1;
                end
            end
        end
    end

    function automatic logic [8:0] expect_out(input int i);
        int unsigned t    = m_t[i];
        int unsigned r    = rd(i);
        int unsigned div  = t % r;
        int unsigned slot = (t / r) % 4;
        int unsigned sel  = 3 - slot;
        logic [3:0]  v    = m_ad[i][4*sel +: 4];
        logic        b    = m_am[i][sel] || (div < gd(i)) || ((t % 16) > m_ab[i]);
        logic        f    = (t != 0) && ((t % (4 * r)) == 0);
        logic [1:0]  s    = slot[1:0];
        return {m_ack[i], s, v, b, f};
    endfunction

    always @(negedge clk) begin
        chk("model_a", obs_a, expect_out(0));
        chk("model_b", obs_b, expect_out(1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int i, input int unsigned slot, input int unsigned div);
        int n = 0;
        while (!((m_t[i] % rd(i)) == div && ((m_t[i] / rd(i)) % 4) == slot) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("wait_pos_bound", n, 0);
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] m, input logic [3:0] b);
        load = 1'b1; digits_in = d; blank_mask_in = m; brightness_in = b;
        step();
        load = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_led"}, led_a, 0);
        chk({tag, "_val"}, val_a, 0);
        chk({tag, "_blank"}, blank_a, 1);
        chk({tag, "_ack"}, ack_a, 0);
        chk({tag, "_fs"}, fs_a, 0);
    endtask

    initial begin
        logic [1:0] exp_slots[9];
        logic [3:0] exp_vals[4];
        int cyc, n_ack, lit, bad;
        exp_slots = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        exp_vals  = '{4'd1, 4'd2, 4'd3, 4'd4};

        // Reset held with inputs toggling
        repeat (4) begin
            load = ~load; digits_in = 16'($urandom);
            blank_mask_in = 4'($urandom); brightness_in = 4'($urandom);
            step();
            chk_reset_vals("rst");
        end
        load = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk("slot_seq", led_a, exp_slots[k]);
            step();
        end
        cyc = 9;
        while (!fs_a && cyc < 40) begin step(); cyc++; end
        chk("first_frame_start", cyc, 16);

        // Load during slot 1, commits at next slot-0 entry
        wait_pos(0, 1, 0);
        pulse_load(16'h1234, 4'h0, 4'hF);
        cyc = 0;
        while (!ack_a && cyc < 40) begin step(); cyc++; end
        chk("commit_ack_fs", {ack_a, fs_a}, 2'b11);
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 0) begin
                chk("commit_val", val_a, exp_vals[k/4]);
                chk("commit_guard_blank", blank_a, 1);
            end else if (k % 4 == 1) begin
                chk("commit_lit", blank_a, 0);
            end
            step();
        end

        // Coalescing: two loads within one frame, one ack
        wait_pos(0, 0, 1);
        pulse_load(16'h1111, 4'h0, 4'hF);
        pulse_load(16'h2222, 4'h0, 4'hF);
        n_ack = 0;
        repeat (32) begin step(); if (ack_a) n_ack++; end
        chk("coalesce_acks", n_ack, 1);
        bad = 0;
        repeat (16) begin if (val_a != 4'd2) bad++; step(); end
        chk("coalesce_vals", bad, 0);

        // Load coincident with wrap while pending
        wait_pos(0, 1, 0);
        pulse_load(16'hABCD, 4'h0, 4'hF);
        wait_pos(0, 3, 3);
        pulse_load(16'h5678, 4'h0, 4'hF);
        chk("coinc_ack1", ack_a, 1);
        chk("coinc_val1", val_a, 4'hA);
        cyc = 0;
        do begin step(); cyc++; end while (!ack_a && cyc < 40);
        chk("coinc_ack2_delay", cyc, 16);
        chk("coinc_val2", val_a, 4'h5);

        // Brightness 3 with slot 1 masked, observed on the 32-cycle-slot instance
        pulse_load(16'h9876, 4'b0100, 4'd3);
        wait_pos(1, 0, 0);
        step();
        wait_pos(1, 0, 0);
        chk("bright_val_slot0", val_b, 4'h9);
        for (int s = 0; s < 3; s++) begin
            lit = 0;
            repeat (32) begin if (!blank_b) lit++; step(); end
            chk("bright_lit_count", lit, (s == 1) ? 0 : 6);
        end

        // Reset in slot 2 with data pending
        wait_pos(0, 1, 0);
        pulse_load(16'h4321, 4'h0, 4'hF);
        wait_pos(0, 2, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (3) begin load = ~load; step(); end
        load = 1'b0;
        chk_reset_vals("midrst_hold");
        reset_n = 1'b1;
        n_ack = 0; lit = 0;
        repeat (48) begin step(); if (ack_a) n_ack++; if (!blank_a) lit++; end
        chk("post_rst_acks", n_ack, 0);
        chk("post_rst_lit", lit, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexing scheduler for the 4-digit seven-segment display. It drives the 2-bit digit-select count that feeds the anode decoder, selects the matching BCD digit, and applies per-digit blanking, brightness PWM and an anti-ghosting guard. New display data is double-buffered behind a load handshake so that a frame never shows a mix of old and new values.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be ≥ GUARD+2.
- DIV_W, 17: prescaler width; 2^DIV_W > REFRESH_DIV-1.
- GUARD, 2: cycles at the start of each slot with the digit forced blank.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle request to stage new display data.
- digits_in  in  16  four BCD nibbles; [15:12] = slot 0 (leftmost) … [3:0] = slot 3.
- blank_mask_in  in  4  1 = digit blanked; bit 3 = slot 0 … bit 0 = slot 3.
- brightness_in  in  4  duty level; 0 = dimmest, 15 = full.
- load_ack  out  1  one-cycle pulse when staged data becomes active.
- LED_activating_counter  out  2  current slot, fed to the anode decoder.
- digit_value  out  4  BCD value for the current slot.
- digit_blank  out  1  1 = segments off this cycle.
- frame_start  out  1  one-cycle pulse on the first cycle of slot 0.

## Operation
- Prescaler div_cnt counts 0…REFRESH_DIV-1 and then wraps. When div_cnt = REFRESH_DIV-1, the slot advances 0→1→2→3→0 on that edge.
- pwm_ph is a free-running 4-bit counter incremented every cycle (15→0 wrap).
- Registers: active {digits, mask, brightness} and pending {digits, mask, brightness}.
- FSM, two states:
  - IDLE: nothing staged. On load, capture the inputs into pending and go to PENDING.
  - PENDING: on load, overwrite pending (latest wins; no extra ack).
  - PENDING: on a frame wrap (slot 3→0 edge), copy pending to active, pulse load_ack, and go to IDLE.
- Simultaneous load and wrap in PENDING: the previously pending data commits and load_ack pulses. The new inputs are captured into pending and the FSM stays PENDING.
- Load and wrap in IDLE: capture into pending only. The data commits at the next wrap.
- digit_value = active digit nibble for the slot.
- digit_blank = 1 when any of the following holds:
  - the active mask bit for the slot is set;
  - div_cnt < GUARD;
  - pwm_ph > active brightness.
- Brightness 15 gives 16/16 duty and brightness 0 gives 1/16 (outside the guard window).
- digit_value is not forced when blanked.
- Non-BCD nibbles (A–F) pass through unchanged; decoding is downstream.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - div_cnt = 0, slot = 0, pwm_ph = 0, FSM IDLE.
  - active digits = 16'h0000, active mask = 4'hF, active brightness = 4'hF, pending = 0.
  - Outputs: LED_activating_counter = 0, digit_value = 0, digit_blank = 1, load_ack = 0, frame_start = 0.
- All outputs are registered and change on the same edge, so slot, value and blank are always mutually consistent.
- The slot holds for exactly REFRESH_DIV cycles. A full frame is 4·REFRESH_DIV cycles.
- frame_start and load_ack (on commit) are high during the first cycle of slot 0. The committed data is displayed in that same cycle (blanked by the guard).
- Load-to-active latency: between 1 cycle and one frame + 1 cycle, depending on frame position.
- Reset mid-frame discards pending data (no ack). The first frame after release starts at slot 0 with frame_start = 0, because frame_start fires only on a 3→0 wrap.
- load is sampled every cycle. The block applies no backpressure and never drops a request; only coalescing occurs.

## Test plan
- Reset check, REFRESH_DIV=4, GUARD=1: hold reset_n=0 with stimulus toggling. Outputs must stay at the reset values listed above. After release, slots must sequence 0,0,0,0,1,1,1,1,2,… and frame_start must first pulse at cycle 16.
- Load commit: load digits_in=16'h1234, mask 0, brightness 15 during slot 1. load_ack and frame_start must pulse together at the next slot-0 entry. digit_value must then read 1,2,3,4 per slot, with digit_blank = 1 only on the first cycle of each slot.
- Coalescing: load 16'h1111 then 16'h2222 within one frame. Exactly one load_ack must fire, and the displayed digits must be 2,2,2,2.
- Load coincident with wrap while PENDING: the old pending data commits with an ack. The new data commits one frame later with a second ack.
- Brightness and mask: brightness_in=3, mask=4'b0100, REFRESH_DIV=32. Slot 1 must be always blank. Other slots must be lit only while pwm_ph ≤ 3 and div_cnt ≥ GUARD.
- Reset mid-operation: assert reset_n=0 in slot 2 with a load pending. All outputs must return to reset values, no load_ack may occur after release, and the display must be blank (mask 4'hF).
